// File: rtl/floating_point_adder_normalizer.sv
// floating_point_adder_normalizer: normalises the FP adder mantissa sum one shift per cycle and packs a binary32 result
//
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready     : operand handshake (carry_in, magnitude_in, sign_in, exponent_in)
//   out_valid/out_ready   : result handshake (result, overflow, underflow)
// Parameter MAX_SHIFT      : shift-cycle limit, >= 23
// Macro FP_NORM_ROUND_EN   : round-to-nearest-even on the carry path (default: truncate)
module floating_point_adder_normalizer #(
  parameter int MAX_SHIFT = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        carry_in,
  input  logic [23:0] magnitude_in,
  input  logic        sign_in,
  input  logic [7:0]  exponent_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t      state_q;
  logic        sign_q;
  logic [23:0] mant_q;
  logic [7:0]  exp_q;
  logic [4:0]  cnt_q;
  logic        out_valid_q;
  logic [31:0] result_q;
  logic        overflow_q;
  logic        underflow_q;
  logic [23:0] carry_mant_d;
  logic [8:0]  carry_exp_d;
  logic        carry_ovf_d;
`ifdef FP_NORM_ROUND_EN
  // magnitude_in[0] is the only dropped bit, so a set bit is an exact tie: bump only when the kept lsb is odd
  logic [24:0] rnd_d;
  assign rnd_d        = {2'b01, magnitude_in[23:1]} + 25'(magnitude_in[0] & magnitude_in[1]);
  assign carry_mant_d = rnd_d[24] ? 24'h800000 : rnd_d[23:0];
  assign carry_exp_d  = {1'b0, exponent_in} + (rnd_d[24] ? 9'd2 : 9'd1);
`else
  assign carry_mant_d = {1'b1, magnitude_in[23:1]};
  assign carry_exp_d  = {1'b0, exponent_in} + 9'd1;
`endif
  assign carry_ovf_d = carry_exp_d >= 9'd255;
  assign in_ready    = state_q == IDLE;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q      <= sign_in;
          cnt_q       <= '0;
          overflow_q  <= 1'b0;
          underflow_q <= 1'b0;
          if (carry_in) begin
            state_q    <= DONE;
            overflow_q <= carry_ovf_d;
            result_q   <= carry_ovf_d ? {sign_in, 8'hFF, 23'h0} : {sign_in, carry_exp_d[7:0], carry_mant_d[22:0]};
          end else if (magnitude_in == '0) begin
            state_q  <= DONE;
            result_q <= '0;
          end else begin
            state_q <= NORM;
            mant_q  <= magnitude_in;
            exp_q   <= exponent_in;
          end
        end
        NORM: if (mant_q[23]) begin
          state_q  <= DONE;
          result_q <= {sign_q, exp_q, mant_q[22:0]};
        end else if (exp_q == 8'd1 || cnt_q == 5'(MAX_SHIFT)) begin
          state_q     <= DONE;
          result_q    <= {sign_q, 31'h0};
          underflow_q <= 1'b1;
        end else begin
          mant_q <= mant_q << 1;
          exp_q  <= exp_q - 8'd1;
          cnt_q  <= cnt_q + 5'd1;
        end
        // first DONE cycle raises out_valid; the handshake edge returns to IDLE
        DONE: if (!out_valid_q) begin
          out_valid_q <= 1'b1;
        end else if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_floating_point_adder_normalizer.sv
// tb_floating_point_adder_normalizer: randomized self-checking bench against a behavioural normaliser model
module tb_floating_point_adder_normalizer;
  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic        carry_in = 0;
  logic [23:0] magnitude_in = '0;
  logic        sign_in = 0;
  logic [7:0]  exponent_in = 8'd1;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  floating_point_adder_normalizer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .carry_in(carry_in), .magnitude_in(magnitude_in), .sign_in(sign_in),
    .exponent_in(exponent_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        o;
    logic        u;
    int          lat;
  } ref_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   pending = 0;
  bit   seen = 0;
  ref_t want;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // value-level model: leading-one search, exponent budget, RNE tie on the carry path
  function automatic ref_t model(bit c, bit [23:0] m, bit [7:0] e, bit s);
    ref_t x;
    longint mm;
    int ee, p, sh;
    bit [23:0] nm;
    x.o = 0; x.u = 0; x.lat = 1; x.r = '0;
    if (c) begin
      mm = ((64'd1 << 24) | 64'(m)) >> 1;
      ee = int'(e) + 1;
`ifdef FP_NORM_ROUND_EN
      if (m[0] && mm[0]) mm++;
      if (mm == (64'd1 << 24)) begin mm = mm >> 1; ee++; end
`endif
      if (ee >= 255) begin x.r = {s, 8'hFF, 23'h0}; x.o = 1; end
      else x.r = {s, ee[7:0], mm[22:0]};
    end else if (m != 0) begin
      p = 23;
      while (!m[p]) p--;
      sh = 23 - p;
      if (int'(e) - sh >= 1) begin
        nm = m << sh;
        x.r = {s, 8'(int'(e) - sh), nm[22:0]};
        x.lat = 2 + sh;
      end else begin
        x.r = {s, 31'h0};
        x.u = 1;
        x.lat = 2 + int'(e) - 1;
      end
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!pending) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_out_valid: got 1, expected 0 (t=%0t)", $time);
      end else begin
        chk("result", result, want.r);
        chk("overflow", 32'(overflow), 32'(want.o));
        chk("underflow", 32'(underflow), 32'(want.u));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (!seen) begin
          seen = 1;
          chk("latency", 32'(cyc - acc_cyc), 32'(want.lat));
        end
      end
    end
  end

  task automatic accept(bit c, bit [23:0] m, bit [7:0] e, bit s);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0, expected 1");
    end
    carry_in = c; magnitude_in = m; exponent_in = e; sign_in = s; in_valid = 1;
    want = model(c, m, e, s);
    seen = 0;
    pending = 1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    carry_in = 1'($urandom); magnitude_in = 24'($urandom); exponent_in = 8'($urandom_range(1, 254));
  endtask

  task automatic run_op(bit c, bit [23:0] m, bit [7:0] e, bit s, int hold);
    int t = 0;
    accept(c, m, e, s);
    @(negedge clk);
    in_valid = 0;
    while (!out_valid && t < 80) begin @(negedge clk); t++; end
    if (!out_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout: got 0, expected 1");
    end
    repeat (hold) @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    pending = 0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("out_valid_after", 32'(out_valid), 32'd0);
  endtask

  task automatic pin(string name, bit c, bit [23:0] m, bit [7:0] e, bit s, logic [31:0] r, bit o, bit u, int lat);
    ref_t x = model(c, m, e, s);
    chk({name, "_model_r"}, x.r, r);
    chk({name, "_model_flags"}, {30'h0, x.o, x.u}, {30'h0, o, u});
    if (lat > 0) chk({name, "_model_lat"}, 32'(x.lat), 32'(lat));
  endtask

  initial begin
    bit [23:0] m;
    bit [7:0]  e;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {30'h0, overflow, underflow}, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 0;

    pin("carry_basic", 1, 24'h000000, 127, 0, 32'h40000000, 0, 0, 1);
    pin("normed", 0, 24'h800000, 127, 1, 32'hBF800000, 0, 0, 2);
    pin("shift23", 0, 24'h000001, 127, 0, 32'h34000000, 0, 0, 25);
    pin("ovf", 1, 24'h000000, 254, 0, 32'h7F800000, 1, 0, 1);
    pin("unf", 0, 24'h000001, 3, 1, 32'h80000000, 0, 1, 0);
`ifdef FP_NORM_ROUND_EN
    pin("round", 1, 24'h000003, 127, 0, 32'h40000002, 0, 0, 1);
`else
    pin("round", 1, 24'h000003, 127, 0, 32'h40000001, 0, 0, 1);
`endif

    run_op(1, 24'h000000, 127, 0, 0);
    run_op(0, 24'h800000, 127, 1, 0);
    run_op(0, 24'h000001, 127, 0, 1);
    run_op(1, 24'h000000, 254, 0, 0);
    run_op(0, 24'h000001, 3, 1, 0);
    run_op(1, 24'h000003, 127, 0, 0);
    run_op(0, 24'h000000, 90, 1, 0);
    run_op(1, 24'hFFFFFF, 253, 1, 0);
    run_op(0, 24'h400000, 1, 0, 0);
    run_op(0, 24'h123456, 100, 0, 5);

    // abort mid-normalisation with an asynchronous reset
    accept(0, 24'h000001, 127, 0);
    @(negedge clk);
    in_valid = 0;
    repeat (5) @(posedge clk);
    #2 reset = 1;
    #1;
    pending = 0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 250; i++) begin
      m = ($urandom_range(0, 9) == 0) ? 24'hFFFFFF : 24'($urandom) >> $urandom_range(0, 24);
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 24)) :
          ($urandom_range(0, 5) == 0) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(1, 254));
      run_op(1'($urandom), m, e, 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
